pipeacc_prog_loader: RTL and testbench

//  Byte-stream program loader; the writer side of the pipeAcc16 instruction/data memories.

---
 rtl/pipeacc_pkg.sv | 32 +++
 rtl/pipeacc_mem_router.sv | 24 ++
 rtl/pipeacc_prog_loader.sv | 201 ++++++++++++++++++++
 tb/tb_pipeacc_prog_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeacc_pkg.sv
// ---------------------------------------------------------------------------
// pipeacc_pkg : shared constants and FSM encoding for the pipeAcc16 loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipeacc_pkg;

    localparam int unsigned L_INS    = 401;
    localparam int unsigned L_TOT    = 1024;
    localparam logic [7:0]  HDR_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CSUM  = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDR_H = 4'd1,
        ST_ADDR_L = 4'd2,
        ST_CNT_H  = 4'd3,
        ST_CNT_L  = 4'd4,
        ST_DATA_H = 4'd5,
        ST_DATA_L = 4'd6,
        ST_WRITE  = 4'd7,
        ST_CSUM   = 4'd8,
        ST_SKIP   = 4'd9
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pipeacc_mem_router.sv
// ---------------------------------------------------------------------------
// pipeacc_mem_router : splits a unified word address into ins/data indices
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeacc_mem_router
    import pipeacc_pkg::*;
(
    input  logic [9:0] addr_i,
    output logic       is_ins_o,
    output logic [8:0] ins_addr_o,
    output logic [9:0] dat_addr_o
);

    always_comb begin
        is_ins_o   = (addr_i < 10'(L_INS));
        ins_addr_o = addr_i[8:0];
        dat_addr_o = addr_i - 10'(L_INS);
    end

endmodule

`default_nettype wire

// File: rtl/pipeacc_prog_loader.sv
// ---------------------------------------------------------------------------
// pipeacc_prog_loader : framed byte-stream loader for the pipeAcc16 memories
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeacc_prog_loader
    import pipeacc_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        ins_we,
    output logic [8:0]  ins_addr,
    output logic        dat_we,
    output logic [9:0]  dat_addr,
    output logic [15:0] wdata,
    output logic        cpu_run,
    output logic        busy,
    output logic [1:0]  err,
    output logic        done
);

    state_t      state_q,    state_d;
    logic [9:0]  addr_q,     addr_d;
    logic [2:0]  cnt_hi_q,   cnt_hi_d;
    logic [10:0] words_q,    words_d;
    logic [11:0] skip_q,     skip_d;
    logic [7:0]  sum_q,      sum_d;
    logic [7:0]  hi_q,       hi_d;
    logic        ins_we_q,   ins_we_d;
    logic        dat_we_q,   dat_we_d;
    logic [8:0]  ins_addr_q, ins_addr_d;
    logic [9:0]  dat_addr_q, dat_addr_d;
    logic [15:0] wdata_q,    wdata_d;
    logic        cpu_run_q,  cpu_run_d;
    logic [1:0]  err_q,      err_d;
    logic        done_q,     done_d;

    logic        w_xfer;
    logic [7:0]  w_sum_nxt;
    logic [10:0] w_cnt;
    logic [11:0] w_end;
    logic        w_is_ins;
    logic [8:0]  w_ins_addr;
    logic [9:0]  w_dat_addr;

    pipeacc_mem_router u_router (
        .addr_i     (addr_q),
        .is_ins_o   (w_is_ins),
        .ins_addr_o (w_ins_addr),
        .dat_addr_o (w_dat_addr)
    );

    assign rx_ready  = (state_q != ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign w_xfer    = rx_valid & rx_ready;
    assign w_sum_nxt = sum_q + rx_data;
    assign w_cnt     = {cnt_hi_q, rx_data};
    assign w_end     = {2'b00, addr_q} + {1'b0, w_cnt};

    assign ins_we   = ins_we_q;
    assign ins_addr = ins_addr_q;
    assign dat_we   = dat_we_q;
    assign dat_addr = dat_addr_q;
    assign wdata    = wdata_q;
    assign cpu_run  = cpu_run_q;
    assign err      = err_q;
    assign done     = done_q;

    always_ff @(posedge clk1) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_hi_q   <= '0;
            words_q    <= '0;
            skip_q     <= '0;
            sum_q      <= '0;
            hi_q       <= '0;
            ins_we_q   <= 1'b0;
            dat_we_q   <= 1'b0;
            ins_addr_q <= '0;
            dat_addr_q <= '0;
            wdata_q    <= '0;
            cpu_run_q  <= 1'b0;
            err_q      <= ERR_NONE;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_hi_q   <= cnt_hi_d;
            words_q    <= words_d;
            skip_q     <= skip_d;
            sum_q      <= sum_d;
            hi_q       <= hi_d;
            ins_we_q   <= ins_we_d;
            dat_we_q   <= dat_we_d;
            ins_addr_q <= ins_addr_d;
            dat_addr_q <= dat_addr_d;
            wdata_q    <= wdata_d;
            cpu_run_q  <= cpu_run_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_hi_d   = cnt_hi_q;
        words_d    = words_q;
        skip_d     = skip_q;
        sum_d      = sum_q;
        hi_d       = hi_q;
        ins_we_d   = 1'b0;
        dat_we_d   = 1'b0;
        ins_addr_d = ins_addr_q;
        dat_addr_d = dat_addr_q;
        wdata_d    = wdata_q;
        cpu_run_d  = cpu_run_q;
        err_d      = err_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: if (w_xfer && rx_data == HDR_BYTE) begin
                state_d   = ST_ADDR_H;
                err_d     = ERR_NONE;
                cpu_run_d = 1'b0;
                sum_d     = '0;
            end
            ST_ADDR_H: if (w_xfer) begin
                addr_d  = {rx_data[1:0], addr_q[7:0]};
                sum_d   = w_sum_nxt;
                state_d = ST_ADDR_L;
            end
            ST_ADDR_L: if (w_xfer) begin
                addr_d  = {addr_q[9:8], rx_data};
                sum_d   = w_sum_nxt;
                state_d = ST_CNT_H;
            end
            ST_CNT_H: if (w_xfer) begin
                cnt_hi_d = rx_data[2:0];
                sum_d    = w_sum_nxt;
                state_d  = ST_CNT_L;
            end
            ST_CNT_L: if (w_xfer) begin
                words_d = w_cnt;
                sum_d   = w_sum_nxt;
                if (w_cnt == '0 || w_end > 12'(L_TOT)) begin
                    // Drain the advertised payload plus the checksum byte
                    err_d   = ERR_RANGE;
                    skip_d  = {w_cnt, 1'b1};
                    state_d = ST_SKIP;
                end else begin
                    state_d = ST_DATA_H;
                end
            end
            ST_DATA_H: if (w_xfer) begin
                hi_d    = rx_data;
                sum_d   = w_sum_nxt;
                state_d = ST_DATA_L;
            end
            ST_DATA_L: if (w_xfer) begin
                wdata_d = {hi_q, rx_data};
                sum_d   = w_sum_nxt;
                if (w_is_ins) begin
                    ins_we_d   = 1'b1;
                    ins_addr_d = w_ins_addr;
                end else begin
                    dat_we_d   = 1'b1;
                    dat_addr_d = w_dat_addr;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                addr_d  = addr_q + 10'd1;
                words_d = words_q - 11'd1;
                state_d = (words_q == 11'd1) ? ST_CSUM : ST_DATA_H;
            end
            ST_CSUM: if (w_xfer) begin
                if (w_sum_nxt == 8'h00) begin
                    cpu_run_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    err_d     = ERR_CSUM;
                end
                state_d = ST_IDLE;
            end
            ST_SKIP: if (w_xfer) begin
                skip_d = skip_q - 12'd1;
                if (skip_q == 12'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeacc_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_pipeacc_prog_loader : table-driven frame bench with a write scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeacc_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        ins_we;
    logic [8:0]  ins_addr;
    logic        dat_we;
    logic [9:0]  dat_addr;
    logic [15:0] wdata;
    logic        cpu_run;
    logic        busy;
    logic [1:0]  err;
    logic        done;

    pipeacc_prog_loader dut (
        .clk1     (clk1),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .ins_we   (ins_we),
        .ins_addr (ins_addr),
        .dat_we   (dat_we),
        .dat_addr (dat_addr),
        .wdata    (wdata),
        .cpu_run  (cpu_run),
        .busy     (busy),
        .err      (err),
        .done     (done)
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
        logic        ins;
    } wr_t;

    typedef struct packed {
        logic [127:0]      b;
        logic [4:0]        nb;
        logic              gaps;
        logic [1:0]        exp_err;
        logic              exp_run;
        logic              exp_done;
        logic [1:0]        nw;
        logic [1:0]        w_ins;
        logic [1:0][9:0]   w_addr;
        logic [1:0][15:0]  w_data;
    } vec_t;

    wr_t  exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   done_cnt = 0;
    bit   mon_en = 1'b0;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [127:0] bytes, input int nb, input logic gaps,
                                input logic [1:0] e, input logic run, input logic dn,
                                input int nw,
                                input logic i0, input logic [9:0] a0, input logic [15:0] d0,
                                input logic i1, input logic [9:0] a1, input logic [15:0] d1);
        vec_t v;
        v.b        = bytes << (8 * (16 - nb));
        v.nb       = 5'(nb);
        v.gaps     = gaps;
        v.exp_err  = e;
        v.exp_run  = run;
        v.exp_done = dn;
        v.nw       = 2'(nw);
        v.w_ins    = {i1, i0};
        v.w_addr   = {a1, a0};
        v.w_data   = {d1, d0};
        return v;
    endfunction

    // Write monitor: pops the scoreboard on every strobe, checks handshake invariant
    always @(negedge clk1) begin
        if (mon_en) begin
            if (rx_ready !== !(ins_we | dat_we))
                chk("rx_ready_vs_write", {31'd0, rx_ready}, {31'd0, !(ins_we | dat_we)});
            if (done) done_cnt++;
            if (ins_we && dat_we) chk("dual_we", 32'd1, 32'd0);
            else if (ins_we || dat_we) begin
                if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_port_ins", {31'd0, ins_we}, {31'd0, e.ins});
                    chk("wr_addr", ins_we ? {23'd0, ins_addr} : {22'd0, dat_addr}, {22'd0, e.addr});
                    chk("wr_data", {16'd0, wdata}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic gap);
        int guard;
        if (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'hA5;
            @(posedge clk1); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard = 0;
        while (!rx_ready && guard < 20) begin
            @(posedge clk1); #1;
            guard++;
        end
        if (guard >= 20) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk1); #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [127:0] bb;
        v  = vecs[idx];
        bb = v.b;
        for (int w = 0; w < int'(v.nw); w++)
            exp_q.push_back('{addr: v.w_addr[w], data: v.w_data[w], ins: v.w_ins[w]});
        done_cnt = 0;
        for (int k = 0; k < int'(v.nb); k++)
            send_byte(bb[127 - 8*k -: 8], v.gaps);
        repeat (4) @(posedge clk1);
        #1;
        chk($sformatf("v%0d_err", idx),     {30'd0, err},     {30'd0, v.exp_err});
        chk($sformatf("v%0d_cpu_run", idx), {31'd0, cpu_run}, {31'd0, v.exp_run});
        chk($sformatf("v%0d_done", idx),    done_cnt,         {31'd0, v.exp_done});
        chk($sformatf("v%0d_busy", idx),    {31'd0, busy},    32'd0);
        chk($sformatf("v%0d_pending", idx), exp_q.size(),     32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_cpu_run"},  {31'd0, cpu_run},  32'd0);
        chk({tag, "_err"},      {30'd0, err},      32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_we"},       {30'd0, ins_we, dat_we}, 32'd0);
        chk({tag, "_addrs"},    {13'd0, ins_addr, dat_addr}, 32'd0);
        chk({tag, "_wdata"},    {16'd0, wdata},    32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(128'hA5_00_00_00_01_5C_00_A3, 8, 1'b0, 2'd0, 1'b1, 1'b1, 1,
                     1'b1, 10'd0, 16'h5C00, 1'b0, 10'd0, 16'h0);
        vecs[1] = mk(128'hA5_01_90_00_02_11_11_22_22_07, 10, 1'b0, 2'd0, 1'b1, 1'b1, 2,
                     1'b1, 10'd400, 16'h1111, 1'b0, 10'd0, 16'h2222);
        vecs[2] = mk(128'hA5_00_00_00_01_5C_00_A4, 8, 1'b0, 2'd1, 1'b0, 1'b0, 1,
                     1'b1, 10'd0, 16'h5C00, 1'b0, 10'd0, 16'h0);
        vecs[3] = mk(128'hA5_03_FF_00_02_11_22_33_44_55, 10, 1'b0, 2'd2, 1'b0, 1'b0, 0,
                     1'b0, 10'd0, 16'h0, 1'b0, 10'd0, 16'h0);
        vecs[4] = vecs[0];
        vecs[5] = mk(128'hA5_00_10_00_00_77, 6, 1'b0, 2'd2, 1'b0, 1'b0, 0,
                     1'b0, 10'd0, 16'h0, 1'b0, 10'd0, 16'h0);
        vecs[6] = mk(128'h00_FF_A5_00_00_00_01_5C_00_A3, 10, 1'b1, 2'd0, 1'b1, 1'b1, 1,
                     1'b1, 10'd0, 16'h5C00, 1'b0, 10'd0, 16'h0);
        vecs[7] = mk(128'hA5_03_FF_00_01_BE_EF_50, 8, 1'b0, 2'd0, 1'b1, 1'b1, 1,
                     1'b0, 10'd622, 16'hBEEF, 1'b0, 10'd0, 16'h0);

        rst = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        check_reset_outputs("por");

        for (int i = 0; i < 8; i++) run_vec(i);

        // Abort after ADDR_L: outputs clear, then a full frame must still load
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(posedge clk1); #1;
        check_reset_outputs("midrst");
        rst = 1'b1;
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
